// File: rtl/vga_fb_pkg.sv
// Shared types and sizes for the VGA frame-buffer arbiter.
package vga_fb_pkg;

    localparam int unsigned ADDR_W          = 19;
    localparam int unsigned DATA_W          = 3;
    localparam int unsigned FIFO_DEPTH_DEF  = 4;
    localparam int unsigned H_DISPLAY       = 640;
    localparam int unsigned V_DISPLAY       = 480;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] pixel_t;

    // Owner of the RAM for the current cycle
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } grant_t;

    // One posted pixel write
    typedef struct packed {
        addr_t  addr;
        pixel_t data;
    } wr_entry_t;

endpackage

// File: rtl/fb_write_fifo.sv
// Synchronous write-posting FIFO holding {addr,data} pixel writes.
module fb_write_fifo
    import vga_fb_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  wr_entry_t                  i_din,
    input  logic                       i_pop,
    output wr_entry_t                  o_dout_c,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_full_c,
    output logic                       o_empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    wr_entry_t        r_mem [DEPTH];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset; the level gates every read of it
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout_c  = r_mem[r_rd_ptr];
    assign o_level   = r_level;
    assign o_empty_c = (r_level == '0);
    assign o_full_c  = (r_level == LVL_W'(DEPTH));

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer RAM arbiter: scanout reads have hard priority, game-logic
// writes are posted through a small FIFO and drained in free cycles.
// Optional macro FB_VBLANK_WRITE_EN: drain writes only during vertical blanking.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vblank,
    input  logic                          rd_req,
    input  addr_t                         rd_addr,
    output pixel_t                        rd_data,
    output logic                          rd_valid,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  addr_t                         wr_addr,
    input  pixel_t                        wr_data,
    output logic                          mem_en,
    output logic                          mem_we,
    output addr_t                         mem_addr,
    output pixel_t                        mem_wdata,
    input  pixel_t                        mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    grant_t           r_grant;
    grant_t           w_grant_nxt;
    logic             r_mem_en;
    logic             r_mem_we;
    addr_t            r_mem_addr;
    pixel_t           r_mem_wdata;
    logic             w_mem_en_nxt;
    logic             w_mem_we_nxt;
    addr_t            w_mem_addr_nxt;
    pixel_t           w_mem_wdata_nxt;
    logic             r_wr_ready;
    logic             r_rd_pend;
    logic             r_rd_valid;
    pixel_t           r_rd_data;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_permit;
    wr_entry_t        w_din;
    wr_entry_t        w_head;
    logic [LVL_W-1:0] w_level;
    logic [LVL_W-1:0] w_level_nxt;

`ifdef FB_VBLANK_WRITE_EN
    assign w_permit = vblank;
`else
    logic w_unused_vblank;
    assign w_unused_vblank = vblank;
    assign w_permit        = 1'b1;
`endif

    assign w_din  = '{addr: wr_addr, data: wr_data};
    assign w_push = wr_valid & r_wr_ready & ~w_full;
    assign w_pop  = (w_grant_nxt == WRITE);

    fb_write_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_din     (w_din),
        .i_pop     (w_pop),
        .o_dout_c  (w_head),
        .o_level   (w_level),
        .o_full_c  (w_full),
        .o_empty_c (w_empty)
    );

    // Next grant and the RAM command that goes with it
    always_comb begin
        w_grant_nxt     = IDLE;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
        if (rd_req) begin
            w_grant_nxt    = READ;
            w_mem_en_nxt   = 1'b1;
            w_mem_addr_nxt = rd_addr;
        end else if (!w_empty && w_permit) begin
            w_grant_nxt     = WRITE;
            w_mem_en_nxt    = 1'b1;
            w_mem_we_nxt    = 1'b1;
            w_mem_addr_nxt  = w_head.addr;
            w_mem_wdata_nxt = w_head.data;
        end
    end

    // Grant state register with its registered RAM command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant     <= IDLE;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_grant     <= w_grant_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    // Level after this edge, so wr_ready can be registered yet exact
    assign w_level_nxt = w_level + LVL_W'(w_push) - LVL_W'(w_pop);

    // Writer back-pressure; held low through reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_wr_ready <= 1'b0;
        else     r_wr_ready <= (w_level_nxt < LVL_W'(FIFO_DEPTH));
    end

    // Two-stage read return: RAM cycle, then capture of the sync RAM output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_pend  <= (r_grant == READ);
            r_rd_valid <= r_rd_pend;
            if (r_rd_pend) r_rd_data <= mem_rdata;
        end
    end

    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign wr_ready   = r_wr_ready;
    assign rd_valid   = r_rd_valid;
    assign rd_data    = r_rd_data;
    assign fifo_level = w_level;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural sync RAM.
// Expectations follow FB_VBLANK_WRITE_EN when the bench is built with it.
module tb_vga_fb_arbiter;
    import vga_fb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        vblank;
    logic        rd_req;
    addr_t       rd_addr;
    pixel_t      rd_data;
    logic        rd_valid;
    logic        wr_valid;
    logic        wr_ready;
    addr_t       wr_addr;
    pixel_t      wr_data;
    logic        mem_en;
    logic        mem_we;
    addr_t       mem_addr;
    pixel_t      mem_wdata;
    pixel_t      mem_rdata = '0;
    logic [2:0]  fifo_level;

    pixel_t      ram [0:(1<<ADDR_W)-1];

    int n_total = 0;
    int n_bad   = 0;

    vga_fb_arbiter #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .vblank     (vblank),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM: read data appears one clock after the access
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int we_cnt;
        int rv_cnt;

        ram[19'h00010] = 3'b101;
        ram[19'h00020] = 3'b010;

        // Reset with stimulus active
        rst      = 1'b1;
        vblank   = 1'b1;
        rd_req   = 1'b1;
        rd_addr  = 19'h00020;
        wr_valid = 1'b1;
        wr_addr  = 19'h00001;
        wr_data  = 3'd1;
        repeat (3) tick();
        check_val("rst_mem_en",   32'(mem_en),     32'd0);
        check_val("rst_rd_valid", 32'(rd_valid),   32'd0);
        check_val("rst_level",    32'(fifo_level), 32'd0);
        check_val("rst_wr_ready", 32'(wr_ready),   32'd0);
        rd_req   = 1'b0;
        wr_valid = 1'b0;
        rst      = 1'b0;
        tick();
        check_val("rel_wr_ready", 32'(wr_ready), 32'd1);
        check_val("rel_mem_en",   32'(mem_en),   32'd0);

        // Read latency: two clocks from request to rd_valid
        rd_req  = 1'b1;
        rd_addr = 19'h00010;
        tick();
        rd_req = 1'b0;
        check_val("lat_k_en",    32'(mem_en),   32'd1);
        check_val("lat_k_we",    32'(mem_we),   32'd0);
        check_val("lat_k_addr",  32'(mem_addr), 32'h10);
        check_val("lat_k_valid", 32'(rd_valid), 32'd0);
        tick();
        check_val("lat_k1_valid", 32'(rd_valid), 32'd0);
        check_val("lat_k1_en",    32'(mem_en),   32'd0);
        tick();
        check_val("lat_k2_valid", 32'(rd_valid), 32'd1);
        check_val("lat_k2_data",  32'(rd_data),  32'd5);
        tick();
        check_val("lat_k3_valid", 32'(rd_valid), 32'd0);

        // Back-pressure: reads hold the RAM while the FIFO fills
        rd_req   = 1'b1;
        rd_addr  = 19'h00020;
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_addr = ADDR_W'(i);
            wr_data = DATA_W'(i + 1);
            tick();
            check_val("bp_fill_we", 32'(mem_we), 32'd0);
        end
        wr_valid = 1'b0;
        check_val("bp_full_level", 32'(fifo_level), 32'd4);
        check_val("bp_full_ready", 32'(wr_ready),   32'd0);
        tick();
        check_val("bp_hold_we",    32'(mem_we),     32'd0);
        check_val("bp_hold_level", 32'(fifo_level), 32'd4);
        rd_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("bp_drain_we",    32'(mem_we),    32'd1);
            check_val("bp_drain_addr",  32'(mem_addr),  32'(i));
            check_val("bp_drain_wdata", 32'(mem_wdata), 32'(i + 1));
        end
        check_val("bp_drain_level", 32'(fifo_level), 32'd0);
        check_val("bp_drain_ready", 32'(wr_ready),   32'd1);
        tick();
        check_val("bp_idle_en", 32'(mem_en), 32'd0);

        // Priority: a queued write yields to a read on the same edge
        rd_req   = 1'b1;
        rd_addr  = 19'h00030;
        wr_valid = 1'b1;
        wr_addr  = 19'h00055;
        wr_data  = 3'd7;
        tick();
        wr_valid = 1'b0;
        check_val("pri_level1", 32'(fifo_level), 32'd1);
        tick();
        check_val("pri_read_en",   32'(mem_en),   32'd1);
        check_val("pri_read_we",   32'(mem_we),   32'd0);
        check_val("pri_read_addr", 32'(mem_addr), 32'h30);
        check_val("pri_level",     32'(fifo_level), 32'd1);
        rd_req = 1'b0;
        tick();
        check_val("pri_wr_we",    32'(mem_we),    32'd1);
        check_val("pri_wr_addr",  32'(mem_addr),  32'h55);
        check_val("pri_wr_wdata", 32'(mem_wdata), 32'd7);
        check_val("pri_wr_level", 32'(fifo_level), 32'd0);
        tick();

        // Drain gating by vertical blanking
        vblank   = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 19'h00100;
        wr_data  = 3'd3;
        tick();
        check_val("vb_push1_we", 32'(mem_we), 32'd0);
        wr_addr = 19'h00101;
        wr_data = 3'd4;
        tick();
        wr_valid = 1'b0;
`ifdef FB_VBLANK_WRITE_EN
        check_val("vb_push2_level", 32'(fifo_level), 32'd2);
        we_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_we) we_cnt++;
        end
        check_val("vb_blocked_we",    32'(we_cnt),     32'd0);
        check_val("vb_blocked_level", 32'(fifo_level), 32'd2);
        check_val("vb_blocked_ready", 32'(wr_ready),   32'd1);
        vblank = 1'b1;
        tick();
        check_val("vb_w1_we",   32'(mem_we),   32'd1);
        check_val("vb_w1_addr", 32'(mem_addr), 32'h100);
        tick();
        check_val("vb_w2_we",   32'(mem_we),   32'd1);
        check_val("vb_w2_addr", 32'(mem_addr), 32'h101);
        check_val("vb_w2_level", 32'(fifo_level), 32'd0);
`else
        check_val("vb_w1_we",    32'(mem_we),     32'd1);
        check_val("vb_w1_addr",  32'(mem_addr),   32'h100);
        check_val("vb_w1_level", 32'(fifo_level), 32'd1);
        tick();
        check_val("vb_w2_we",    32'(mem_we),     32'd1);
        check_val("vb_w2_addr",  32'(mem_addr),   32'h101);
        check_val("vb_w2_wdata", 32'(mem_wdata),  32'd4);
        check_val("vb_w2_level", 32'(fifo_level), 32'd0);
`endif
        vblank = 1'b1;
        tick();
        check_val("vb_idle_we", 32'(mem_we), 32'd0);

        // Reset mid-operation: queued writes and in-flight reads are dropped
        rd_req   = 1'b1;
        rd_addr  = 19'h00010;
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_addr = ADDR_W'(19'h200 + i);
            wr_data = DATA_W'(i + 2);
            tick();
        end
        wr_valid = 1'b0;
        check_val("mr_level3", 32'(fifo_level), 32'd3);
        rst    = 1'b1;
        rd_req = 1'b0;
        #1;
        check_val("mr_rst_level", 32'(fifo_level), 32'd0);
        check_val("mr_rst_en",    32'(mem_en),     32'd0);
        check_val("mr_rst_valid", 32'(rd_valid),   32'd0);
        check_val("mr_rst_ready", 32'(wr_ready),   32'd0);
        tick();
        rst = 1'b0;
        we_cnt = 0;
        rv_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_we)   we_cnt++;
            if (rd_valid) rv_cnt++;
        end
        check_val("mr_post_we",    32'(we_cnt),     32'd0);
        check_val("mr_post_valid", 32'(rv_cnt),     32'd0);
        check_val("mr_post_level", 32'(fifo_level), 32'd0);
        check_val("mr_post_ready", 32'(wr_ready),   32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
